// File: rtl/uart_frame_tx.sv
// ============================================================================
// uart_frame_tx : serialises one BYTES-wide word per handshake as 8N1 UART,
// byte 0 and bit 0 first. Define UART_TX_PARITY_EN for 8E1 (even parity).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_frame_tx #(
  parameter int CLK_DIV = 4,
  parameter int BYTES   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  output logic               tx,
  output logic               busy,
  output logic               bit_tick
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [8*BYTES-1:0]  sreg_q, sreg_d;
  logic                tx_q, tx_d;
  logic                tick_q, tick_d;
  logic                ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sreg_d  = sreg_q;
    tx_d    = tx_q;
    tick_d  = 1'b0;
    ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == S_IDLE) begin
      if (in_valid && ready_q) begin
        state_d = S_START;
        sreg_d  = in_data;
        div_d   = '0;
        byte_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        tick_d  = 1'b1;
        ready_d = 1'b0;
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      // Bit boundary: outputs are registered, so the next bit's level is set here.
      div_d  = '0;
      tick_d = 1'b1;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = sreg_q[0];
`ifdef UART_TX_PARITY_EN
          parity_d = ^sreg_q[7:0];
`endif
        end
        S_DATA: begin
          sreg_d = sreg_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sreg_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
`endif
        S_STOP: begin
          if (byte_q == BYTE_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            tick_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          tick_d  = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sreg_q  <= '0;
      tx_q    <= 1'b1;
      tick_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sreg_q  <= sreg_d;
      tx_q    <= tx_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign bit_tick = tick_q;
  assign in_ready = ready_q;
  assign busy     = ~ready_q;

endmodule

`default_nettype wire

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serialising UART transmitter for the debug link: it returns multi-byte responses (for example a peek result {id, data32}) to the host over `tx`, the opposite direction of the command receiver on `rx`. It accepts one BYTES-wide word per valid/ready handshake and sends it least-significant byte first. Each byte is sent LSB first in 8N1 format, with a bit period of CLK_DIV clocks. It sits between the NoC-side peek logic and the top-level `tx` pin.

## Interface
- CLK_DIV, 4, clocks per UART bit; legal range ≥ 2.
- BYTES, 5, bytes per frame; legal range ≥ 1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  8*BYTES  payload; byte k = in_data[8k+7:8k]; byte 0 is sent first.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (inverse of in_ready).
- bit_tick  output  1  one-cycle pulse on the first cycle of every transmitted bit.

## Operation
- States and transitions:
  - IDLE → START when in_valid && in_ready; in_data is latched into the shift register.
  - START → DATA.
  - DATA → DATA for 8 bits, then → STOP.
  - STOP → START if bytes remain, else → IDLE.
- Each state (and each data bit) lasts exactly CLK_DIV cycles, counted by a divider of width $clog2(CLK_DIV).
- Bit order:
  - Data: shift register shifts right; tx = sreg[0].
  - Bytes: byte counter runs 0..BYTES-1; byte 0 is sent first.
- Line levels: start bit = 0, stop bit = 1, tx = 1 in IDLE.
- in_data changes are ignored outside the accept cycle.
- in_valid may drop while busy without effect.
- No abort mechanism: a frame, once accepted, always completes unless rst is asserted.

## Timing
- Reset values (asynchronous, take effect immediately on rst):
  - State, counters, outputs: state = IDLE, tx = 1, in_ready = 1, busy = 0, bit_tick = 0, divider = 0, byte and bit counters = 0.
- Accept at cycle t (in_valid && in_ready on the rising edge):
  - Cycle t+1: in_ready = 0, tx = 0 (start bit), bit_tick = 1.
- Frame length: BYTES*10*CLK_DIV cycles from t+1 (11 bits per byte with parity).
- Frame end: the last stop-bit cycle is t+BYTES*10*CLK_DIV, and in_ready = 1 on the following cycle.
- Back-to-back frames: the minimum inter-frame gap is exactly 1 idle cycle (tx = 1) when in_valid is held high.
- No gaps between bytes within a frame: the stop bit is followed directly by the next start bit.
- Reset mid-frame: tx returns high asynchronously and the partial frame is discarded; after rst drops, the block is in IDLE.

## Configuration
- UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Byte time becomes 11 bits.
- UART_TX_PARITY_EN undefined: 8N1, 10 bits per byte, no PARITY state in the logic.

## Test plan
- Reset: assert rst for 3 cycles mid-run → tx = 1, in_ready = 1, busy = 0, bit_tick = 0 while rst is high and on the first cycle after release.
- Single frame, CLK_DIV = 4, BYTES = 5, in_data = {8'h03, 32'h0000023C}:
  - tx bytes in order: 0x3C, 0x02, 0x00, 0x00, 0x03.
  - First byte line pattern: 0, 0,0,1,1,1,1,0,0, 1 — each bit 4 cycles.
  - in_ready returns at t+201.
- bit_tick: same frame → exactly 50 pulses spaced 4 cycles apart; the first pulse is at t+1.
- Back-to-back: in_valid held high with words 0x03_0000023C then 0x03_0000023D → exactly 1 idle-high cycle between frames; the second frame's first data byte is 0x3D.
- Reset mid-frame: rst asserted during byte 2 → tx = 1 in the same cycle; after release, a new accept sends a clean frame.
- Parity (UART_TX_PARITY_EN defined):
  - Byte 0x3C → parity bit 0; byte 0x07 → parity bit 1.
  - Frame length becomes 5*11*4 = 220 cycles.
